// File: rtl/mux_4x1_arbiter_pkg.sv
// Shared constants for the 4:1 result-mux arbiter: FSM encoding, widths, defaults.
// Pure declarations; no logic.
package mux_4x1_arbiter_pkg;

  localparam int NUM_REQ              = 4;
  localparam int SEL_W                = 2;
  localparam int DEF_TIMEOUT_CYCLES   = 16;
  localparam int DEF_CNT_W            = 5;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BUSY      = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_4x1_arbiter_if.sv
// Request/grant bundle between the arbiter (master) and requesters/consumer (slave).
// Combinational wiring only.
interface mux_4x1_arbiter_if;
  import mux_4x1_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               start;
  logic               busy;
  logic               timeout;

  modport master (
    input  req,
    input  done,
    output grant,
    output sel,
    output start,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  grant,
    input  sel,
    input  start,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/mux_4x1_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping.
// Zero latency; valid_o low when no request is set.
module rr_pick4
  import mux_4x1_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [SEL_W-1:0]   winner_o,
  output logic               valid_o
);

  logic [SEL_W-1:0] idx;

  // Scan farthest-first so the nearest candidate after ptr_i overwrites last.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr_i + SEL_W'(k + 1);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_4x1_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4:1 result mux with a BUSY watchdog.
// Grant 1 cycle after request; held until done or watchdog, then one dead cycle.
module mux_4x1_arbiter
  import mux_4x1_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RESET,
  mux_4x1_arbiter_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state_q,   state_d;
  logic [NUM_REQ-1:0] grant_q,   grant_d;
  logic [SEL_W-1:0]   sel_q,     sel_d;
  logic [SEL_W-1:0]   ptr_q,     ptr_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               start_q,   start_d;
  logic               timeout_q, timeout_d;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_vld;

  rr_pick4 u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BUSY;
          grant_d = onehot4(pick_idx);
          sel_d   = pick_idx;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Done wins over a coincident watchdog expiry.
        if (bus.done || (cnt_q == CNT_LAST)) begin
          state_d   = ST_RELEASE;
          grant_d   = '0;
          ptr_d     = sel_q;
          cnt_d     = '0;
          timeout_d = ~bus.done;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= SEL_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.start   = start_q;
  assign bus.busy    = (state_q == ST_BUSY);
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_4x1_arbiter.sv
// Directed bench for mux_4x1_arbiter: reset, fairness, hold, watchdog, done-vs-expiry, async reset.
module tb_mux_4x1_arbiter;

  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_bad;

  mux_4x1_arbiter_if bus ();

  mux_4x1_arbiter #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check structural invariants away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    chk("inv_onehot", 32'($onehot0(bus.grant)), 32'd1);
    chk("inv_busy",   32'(bus.busy), 32'(|bus.grant));
    chk("inv_start",  32'(!bus.start || bus.busy), 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic st, input logic b, input logic to);
    chk({tag, "_grant"},   32'(bus.grant),   32'(g));
    chk({tag, "_sel"},     32'(bus.sel),     32'(s));
    chk({tag, "_start"},   32'(bus.start),   32'(st));
    chk({tag, "_busy"},    32'(bus.busy),    32'(b));
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'(to));
  endtask

  initial begin
    logic [1:0] order [5];
    logic [3:0] ohs   [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ohs   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n_cmp = 0;
    n_bad = 0;

    RESET    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #12;
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // Single requester, done two cycles later
    tick();
    chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.req = 4'b0001;
    tick();
    chk_out("t1_grant", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    chk_out("t1_hold", 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    chk_out("t1_release", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick();
    chk_out("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Fairness from fresh reset: all four requesting
    RESET = 1'b0;
    #2;
    RESET   = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr%0d_grant", i), ohs[i], order[i], 1'b1, 1'b1, 1'b0);
      tick();
      chk("rr_start_drop", 32'(bus.start), 32'd0);
      bus.done = 1'b1;
      tick();
      chk("rr_release", 32'(bus.grant), 32'd0);
      bus.done = 1'b0;
      tick();
      chk("rr_gap", 32'(bus.grant), 32'd0);
    end

    // Grant held while REQ changes; last winner 0
    bus.req = 4'b0100;
    tick();
    chk_out("hold_grant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    bus.req = 4'b0010;
    tick();
    tick();
    chk_out("hold_mid", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    chk_out("hold_rel", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    chk_out("hold_idle_sel", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);

    // Watchdog: ptr=2, REQ 1010 -> requester 3, expires after 16 BUSY cycles
    bus.req = 4'b1010;
    tick();
    chk_out("wd_grant", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk_out("wd_last_busy", 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("wd_expire", 4'b0000, 2'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("wd_after", 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("wd_next", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);

    // Done on the expiry cycle: normal release, no timeout
    for (int i = 0; i < 15; i++) tick();
    chk_out("de_last_busy", 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    chk_out("de_release", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    chk("de_no_timeout", 32'(bus.timeout), 32'd0);

    // Async reset mid-BUSY
    bus.req = 4'b0100;
    tick();
    chk_out("ar_grant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    #2;
    RESET = 1'b0;
    #1;
    chk_out("ar_clear", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    RESET   = 1'b1;
    bus.req = 4'b1001;
    tick();
    chk_out("ar_regrant", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
